// File: rtl/deco_pkg.sv
// deco_pkg: shared definitions for the deco_seq_burst slice.
// Holds the sequencer state type, default widths and the byte table
// contents. Table positions beyond TABLE_LAST read as all-ones.
package deco_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned REF_W_DEF  = 6;
  localparam int unsigned TABLE_LAST = 13;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PRESENT,
    ST_DONE
  } deco_state_e;

  // Defined table entries, index 0..TABLE_LAST.
  localparam logic [7:0] DECO_TABLE [TABLE_LAST+1] = '{
    8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h29,
    8'h41, 8'h42, 8'h43, 8'h44,
    8'hF0
  };

endpackage

// File: rtl/deco_seq_burst_if.sv
// deco_seq_burst_if: request/response bundle between a consumer and
// deco_seq_burst.
//   master : drives Start, Mode, Ref, Abort, Ack; observes the outputs.
//   slave  : the sequencer; drives Dato_out, Valid, Busy, Done, Idx.
// With DECO_PARITY_EN defined an extra Parity signal is carried.
interface deco_seq_burst_if
  import deco_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REF_W  = REF_W_DEF,
  parameter int unsigned IDX_W  = 4
);

  logic              Start;
  logic              Mode;
  logic [REF_W-1:0]  Ref;
  logic              Abort;
  logic              Ack;
  logic [DATA_W-1:0] Dato_out;
  logic              Valid;
  logic              Busy;
  logic              Done;
  logic [IDX_W-1:0]  Idx;
`ifdef DECO_PARITY_EN
  logic              Parity;

  modport master (
    output Start, Mode, Ref, Abort, Ack,
    input  Dato_out, Valid, Busy, Done, Idx, Parity
  );

  modport slave (
    input  Start, Mode, Ref, Abort, Ack,
    output Dato_out, Valid, Busy, Done, Idx, Parity
  );
`else
  modport master (
    output Start, Mode, Ref, Abort, Ack,
    input  Dato_out, Valid, Busy, Done, Idx
  );

  modport slave (
    input  Start, Mode, Ref, Abort, Ack,
    output Dato_out, Valid, Busy, Done, Idx
  );
`endif

endinterface

// File: rtl/deco_rom.sv
// deco_rom: combinational byte table lookup.
//   idx    : table index
//   data_c : table byte (all-ones where the table has no entry)
module deco_rom
  import deco_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REF_W  = REF_W_DEF
) (
  input  logic [REF_W-1:0]  idx,
  output logic [DATA_W-1:0] data_c
);

  always_comb begin
    data_c = '1;
    if (32'(idx) <= TABLE_LAST) begin
      data_c = DATA_W'(DECO_TABLE[4'(idx)]);
    end
  end

endmodule

// File: rtl/deco_seq_burst.sv
// deco_seq_burst: reads one byte, or a burst of SEQ_LEN bytes, from the
// deco table starting at a requested index and hands each byte to a
// consumer with a Valid/Ack handshake.
//   Clock, Reset : rising-edge clock, asynchronous active-low reset
//   bus (slave)  : Start/Mode/Ref request, Abort, Ack in;
//                  Dato_out, Valid, Busy, Done, Idx out (all registered)
// Optional: define DECO_PARITY_EN to add a registered Parity output
// (XOR of Dato_out).
module deco_seq_burst
  import deco_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned REF_W   = REF_W_DEF,
  parameter int unsigned SEQ_LEN = 9
) (
  input  logic            Clock,
  input  logic            Reset,
  deco_seq_burst_if.slave bus
);

  localparam int unsigned     IDX_W  = $clog2(SEQ_LEN);
  localparam logic [IDX_W-1:0] LAST_K = IDX_W'(SEQ_LEN - 1);

  deco_state_e       state;
  logic [REF_W-1:0]  ref_q;
  logic              mode_q;
  logic [IDX_W-1:0]  k_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;
  logic [REF_W-1:0]  addr_c;
  logic [DATA_W-1:0] rom_data_c;

  // Table address wraps naturally at 2^REF_W.
  assign addr_c = ref_q + REF_W'(k_q);

  deco_rom #(
    .DATA_W (DATA_W),
    .REF_W  (REF_W)
  ) u_rom (
    .idx    (addr_c),
    .data_c (rom_data_c)
  );

`ifdef DECO_PARITY_EN
  logic parity_q;
  assign bus.Parity = parity_q;
`endif

  // Sequencer. PRESENT spends its first cycle raising Valid, so Ack is
  // only honoured once Valid is already visible to the consumer.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state   <= ST_IDLE;
      ref_q   <= '0;
      mode_q  <= 1'b0;
      k_q     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DECO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else if (state != ST_IDLE && bus.Abort) begin
      // Abort beats any Ack in the same cycle and never reports Done.
      state   <= ST_IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.Start) begin
            ref_q  <= bus.Ref;
            mode_q <= bus.Mode;
            k_q    <= '0;
            busy_q <= 1'b1;
            state  <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          data_q <= rom_data_c;
`ifdef DECO_PARITY_EN
          parity_q <= ^rom_data_c;
`endif
          state  <= ST_PRESENT;
        end
        ST_PRESENT: begin
          if (!valid_q) begin
            valid_q <= 1'b1;
          end else if (bus.Ack) begin
            valid_q <= 1'b0;
            if (!mode_q || k_q == LAST_K) begin
              done_q <= 1'b1;
              state  <= ST_DONE;
            end else begin
              k_q   <= k_q + IDX_W'(1);
              state <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.Dato_out = data_q;
  assign bus.Valid    = valid_q;
  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;
  assign bus.Idx      = k_q;

endmodule

// File: tb/tb_deco_seq_burst.sv
// tb_deco_seq_burst: self-checking bench for deco_seq_burst.
// Expected bytes come from a table built from the published contents and
// indexed with modular arithmetic; timing expectations are counted in
// falling edges between a request/acknowledge and the next Valid.
// Define DECO_PARITY_EN to also check Parity.
module tb_deco_seq_burst;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned REF_W   = 6;
  localparam int unsigned SEQ_LEN = 9;
  localparam int unsigned IDX_W   = $clog2(SEQ_LEN);
  localparam int unsigned TAB_N   = 1 << REF_W;

  logic Clock = 1'b0;
  logic Reset = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] exp_tab [TAB_N];

  deco_seq_burst_if #(.DATA_W(DATA_W), .REF_W(REF_W), .IDX_W(IDX_W)) bus ();

  deco_seq_burst #(
    .DATA_W  (DATA_W),
    .REF_W   (REF_W),
    .SEQ_LEN (SEQ_LEN)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One request from an idle DUT, called at a falling edge.
  //   ack_hi   : keep Ack high the whole time
  //   hold_*   : range of cycles Ack is held low once Valid is seen
  //   abort_k  : byte on whose Ack Abort is also raised (-1 = none)
  //   poke     : raise random Start/Ref/Mode while busy
  //   reset_k  : byte during which Reset is pulled low (-1 = none)
  task automatic run_op(input int r, input bit m, input bit ack_hi,
                        input int hold_min, input int hold_max,
                        input int abort_k, input bit poke, input int reset_k);
    int n_bytes;
    int waited;
    int hold;
    logic [DATA_W-1:0] exp_b;
    n_bytes = m ? int'(SEQ_LEN) : 1;
    bus.Ref   = REF_W'(r);
    bus.Mode  = m;
    bus.Start = 1'b1;
    bus.Ack   = ack_hi;
    bus.Abort = 1'b0;
    for (int k = 0; k < n_bytes; k++) begin
      exp_b  = exp_tab[(r + k) % int'(TAB_N)];
      waited = (k == 0) ? 0 : 1;
      do begin
        @(negedge Clock);
        waited++;
        bus.Start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.Ref   = REF_W'($urandom);
        bus.Mode  = 1'($urandom);
        bus.Ack   = ack_hi ? 1'b1 : 1'($urandom_range(0, 1));
        if (!bus.Valid) check("busy_wait", 32'(bus.Busy), 32'd1);
      end while (!bus.Valid && waited < 8);
      if (!bus.Valid) begin
        check("valid_timeout", 32'(bus.Valid), 32'd1);
        bus.Start = 1'b0;
        bus.Ack   = 1'b0;
        return;
      end
      check("latency", 32'(waited), 32'd3);
      if (reset_k == k) begin
        check("data_pre_rst", 32'(bus.Dato_out), 32'(exp_b));
        bus.Start = 1'b0;
        bus.Ack   = 1'b0;
        #2 Reset = 1'b0;
        #1;
        check("rst_data",  32'(bus.Dato_out), 32'd0);
        check("rst_valid", 32'(bus.Valid), 32'd0);
        check("rst_busy",  32'(bus.Busy), 32'd0);
        check("rst_done",  32'(bus.Done), 32'd0);
        check("rst_idx",   32'(bus.Idx), 32'd0);
        return;
      end
      hold = ack_hi ? 0 : int'($urandom_range(hold_min, hold_max));
      for (int h = 0; ; h++) begin
        check("data", 32'(bus.Dato_out), 32'(exp_b));
        check("idx",  32'(bus.Idx), 32'(k));
        check("valid", 32'(bus.Valid), 32'd1);
        check("done_mid", 32'(bus.Done), 32'd0);
`ifdef DECO_PARITY_EN
        check("parity", 32'(bus.Parity), 32'(^exp_b));
`endif
        bus.Ack   = (h == hold);
        bus.Abort = (h == hold) && (k == abort_k);
        bus.Start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.Ref   = REF_W'($urandom);
        if (h == hold) break;
        @(negedge Clock);
      end
      @(negedge Clock);
      bus.Start = 1'b0;
      bus.Abort = 1'b0;
      bus.Ack   = ack_hi;
      check("valid_after_ack", 32'(bus.Valid), 32'd0);
      if (k == abort_k) begin
        check("abort_done", 32'(bus.Done), 32'd0);
        check("abort_busy", 32'(bus.Busy), 32'd0);
        @(negedge Clock);
        check("abort_done2", 32'(bus.Done), 32'd0);
        check("abort_hold_data", 32'(bus.Dato_out), 32'(exp_b));
        return;
      end
      if (k == n_bytes - 1) begin
        check("done_pulse", 32'(bus.Done), 32'd1);
        check("done_busy", 32'(bus.Busy), 32'd1);
        @(negedge Clock);
        check("done_clear", 32'(bus.Done), 32'd0);
        check("idle_busy", 32'(bus.Busy), 32'd0);
        check("idle_valid", 32'(bus.Valid), 32'd0);
        check("idle_hold_data", 32'(bus.Dato_out), 32'(exp_b));
      end else begin
        check("done_early", 32'(bus.Done), 32'd0);
        check("busy_mid", 32'(bus.Busy), 32'd1);
      end
    end
    bus.Ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r;
    bit m;
    int ab;

    for (int i = 0; i < int'(TAB_N); i++) exp_tab[i] = '1;
    for (int i = 0; i <= 8; i++) exp_tab[i] = DATA_W'(8'h21 + i);
    for (int i = 0; i <= 3; i++) exp_tab[9 + i] = DATA_W'(8'h41 + i);
    exp_tab[13] = DATA_W'(8'hF0);

    bus.Start = 1'b0;
    bus.Mode  = 1'b0;
    bus.Ref   = '0;
    bus.Abort = 1'b0;
    bus.Ack   = 1'b0;

    #1;
    check("reset_data",  32'(bus.Dato_out), 32'd0);
    check("reset_valid", 32'(bus.Valid), 32'd0);
    check("reset_busy",  32'(bus.Busy), 32'd0);
    check("reset_done",  32'(bus.Done), 32'd0);
    check("reset_idx",   32'(bus.Idx), 32'd0);

    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b1;

    // Full burst from 0 with Ack held high: 21..29.
    run_op(0, 1'b1, 1'b1, 0, 0, -1, 1'b0, -1);
    // Wrapping burst from 62: FF,FF,21..27.
    run_op(62, 1'b1, 1'b0, 0, 2, -1, 1'b0, -1);
    // Single byte F0 with Ack held off for 5 cycles.
    run_op(13, 1'b0, 1'b0, 5, 5, -1, 1'b0, -1);
    // Burst from 9 aborted on the 3rd Ack, with stray Starts.
    run_op(9, 1'b1, 1'b0, 0, 2, 2, 1'b1, -1);
    // Reset during the 4th byte, then a Start on the first edge after release.
    run_op(0, 1'b1, 1'b0, 0, 1, -1, 1'b0, 3);
    @(negedge Clock);
    Reset = 1'b1;
    run_op(0, 1'b0, 1'b0, 0, 1, -1, 1'b0, -1);

    // Randomized requests.
    for (int t = 0; t < 40; t++) begin
      r  = int'($urandom_range(0, TAB_N - 1));
      m  = 1'($urandom);
      n  = m ? int'(SEQ_LEN) : 1;
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      run_op(r, m, 1'b0, 0, 3, ab, 1'($urandom), -1);
      if ($urandom_range(0, 1) == 1) @(negedge Clock);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/deco_seq_burst.md
DECO_SEQ_BURST -- requirements
Module: deco_seq_burst

Interface
REQ-001 SHALL have parameter DATA_W, default 8, output byte width.
REQ-002 SHALL have parameter REF_W, default 6, table index width (2^REF_W entries).
REQ-003 SHALL have parameter SEQ_LEN, default 9, bytes per burst (2..2^REF_W).
REQ-004 SHALL have port Clock  in  1  sole clock, rising edge.
REQ-005 SHALL have port Reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port Start  in  1  request, sampled only in IDLE.
REQ-007 SHALL have port Mode  in  1  0 = single byte, 1 = burst of SEQ_LEN bytes; latched at Start.
REQ-008 SHALL have port Ref  in  REF_W  start table index; latched at Start.
REQ-009 SHALL have port Abort  in  1  terminate current operation.
REQ-010 SHALL have port Ack  in  1  consumer accepts Dato_out while Valid=1.
REQ-011 SHALL have port Dato_out  out  DATA_W  registered table byte.
REQ-012 SHALL have port Valid  out  1  Dato_out presented.
REQ-013 SHALL have port Busy  out  1  high in every non-IDLE state.
REQ-014 SHALL have port Done  out  1  one-cycle pulse on normal completion.
REQ-015 SHALL have port Idx  out  $clog2(SEQ_LEN)  position k of the current byte within the burst.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, PRESENT, DONE.
REQ-017 IDLE: Start=1 -> latch Ref and Mode, k=0, go to FETCH.
REQ-018 FETCH: Dato_out <= table[(Ref+k) mod 2^REF_W]; go to PRESENT; Valid=0.
REQ-019 PRESENT: Valid=1, Dato_out and Idx held stable until Ack=1.
REQ-020 PRESENT with Ack=1: if Mode=0 or k=SEQ_LEN-1 -> DONE; else k+1 -> FETCH.
REQ-021 DONE: Done=1 for exactly one cycle, then IDLE.
REQ-022 Latency: Start sampled at edge n -> Valid=1 after edge n+2; each subsequent byte Valid 2 cycles after the previous Ack.
REQ-023 Index addition SHALL wrap modulo 2^REF_W (no saturation).
REQ-024 Table entries without a defined value SHALL read all-ones.
REQ-025 Start in any non-IDLE state SHALL be ignored, with no re-latching.
REQ-026 Abort=1 in any non-IDLE state -> IDLE next edge, Valid=0, Done not asserted; Abort wins over a simultaneous Ack.
REQ-027 Ack while Valid=0 SHALL be ignored.
REQ-028 Dato_out SHALL keep its last value in IDLE.

Reset
REQ-029 Reset=0 SHALL immediately force IDLE, Dato_out=0, Valid=0, Busy=0, Done=0, Idx=0, and clear the latched Ref/Mode, including mid-burst.
REQ-030 After deassertion, the first Start SHALL be accepted on the first rising edge.

Configuration
REQ-031 With DECO_PARITY_EN defined, there SHALL be an extra output Parity (1 bit) = XOR of all Dato_out bits, registered together with Dato_out and reset to 0.
REQ-032 Without DECO_PARITY_EN, the Parity port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-033 Package deco_pkg SHALL hold the FSM state typedef, DATA_W/REF_W defaults and the table constant: idx 0-8 = 8'h21..8'h29, idx 9-12 = 8'h41..8'h44, idx 13 = 8'hF0, all others 8'hFF.
REQ-034 Combinational sub-module deco_rom (index in, byte out) SHALL implement the table; deco_seq_burst SHALL hold the FSM, counter and output registers.

Verification
REQ-035 Ref=0, Mode=1, Ack held high -> Dato_out 21,22,...,29 with Idx 0..8; Done pulses once, the cycle after the 9th Ack.
REQ-036 Ref=62, Mode=1 -> wrap: FF,FF,21,22,23,24,25,26,27.
REQ-037 Ref=13, Mode=0 -> single F0, Valid 2 cycles after Start; Done after its Ack; Ack delayed 5 cycles keeps F0 stable.
REQ-038 Burst Ref=9, Abort together with the 3rd Ack -> IDLE, no Done; a new Start during the burst is ignored.
REQ-039 Reset=0 during the 4th byte of a burst -> all outputs 0 asynchronously; a Start after release with Ref=0 yields 21.
REQ-040 With DECO_PARITY_EN: byte 21 -> Parity=0, byte 23 -> Parity=1, byte F0 -> Parity=0.
